// File: rtl/freelist_ckpt_pkg.sv
// Shared constants and types for the checkpointed physical-register free list.
// Default configuration lives here; the top derives its own widths from its parameters.
package freelist_ckpt_pkg;

  localparam int unsigned DEF_WIDTH    = 2;
  localparam int unsigned DEF_PRF_SIZE = 64;
  localparam int unsigned DEF_ARF_SIZE = 32;
  localparam int unsigned DEF_NUM_CKPT = 4;

  localparam int unsigned FL_SIZE = DEF_PRF_SIZE - DEF_ARF_SIZE;
  localparam int unsigned PTR_W   = $clog2(FL_SIZE) + 1;
  localparam int unsigned TAG_W   = $clog2(DEF_PRF_SIZE);
  localparam int unsigned CKPT_W  = $clog2(DEF_NUM_CKPT);

  typedef logic [PTR_W-1:0]  fl_ptr_t;
  typedef logic [CKPT_W-1:0] ckpt_id_t;
  typedef logic [TAG_W-1:0]  tag_t;

endpackage

// File: rtl/freelist_ckpt_bank.sv
// Branch checkpoint storage: one registered write port, one combinational read port.
module freelist_ckpt_bank #(
  parameter int unsigned NumCkpt = 4,
  parameter int unsigned PtrW    = 6
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       we_i,
  input  logic [$clog2(NumCkpt)-1:0] wid_i,
  input  logic [PtrW-1:0]            wdata_i,
  input  logic [$clog2(NumCkpt)-1:0] rid_i,
  output logic [PtrW-1:0]            rdata_o
);

  logic [PtrW-1:0] slot_q [NumCkpt];
  logic [PtrW-1:0] slot_d [NumCkpt];

  always_comb begin
    slot_d = slot_q;
    if (we_i) slot_d[wid_i] = wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumCkpt; i++) slot_q[i] <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign rdata_o = slot_q[rid_i];

endmodule

// File: rtl/freelist_ckpt.sv
// Multi-lane circular free list of PRF tags with branch checkpoints and flush recovery.
module freelist_ckpt
  import freelist_ckpt_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned PRF_SIZE = DEF_PRF_SIZE,
  parameter int unsigned ARF_SIZE = DEF_ARF_SIZE,
  parameter int unsigned NUM_CKPT = DEF_NUM_CKPT
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [WIDTH-1:0]                         disp_en,
  output logic [WIDTH-1:0][$clog2(PRF_SIZE)-1:0]   free_tag,
  output logic [WIDTH-1:0]                         free_valid,
  output logic [$clog2(PRF_SIZE-ARF_SIZE):0]       avail_cnt,
  input  logic [WIDTH-1:0]                         retire_en,
  input  logic [WIDTH-1:0][$clog2(PRF_SIZE)-1:0]   retire_tag,
  input  logic                                     ckpt_save,
  input  logic [$clog2(NUM_CKPT)-1:0]              ckpt_id,
  input  logic                                     restore_en,
  input  logic [$clog2(NUM_CKPT)-1:0]              restore_id,
  input  logic                                     flush_en,
  output logic                                     err
);

  localparam int unsigned FlSize = PRF_SIZE - ARF_SIZE;
  localparam int unsigned IdxW   = $clog2(FlSize);
  localparam int unsigned PtrW   = IdxW + 1;
  localparam int unsigned TagW   = $clog2(PRF_SIZE);

  // Advance a {wrap, index} pointer by k; the index wraps at FlSize, not 2^IdxW.
  function automatic logic [PtrW-1:0] ptr_add(logic [PtrW-1:0] p, int unsigned k);
    int unsigned s;
    logic        w;
    s = 32'(p[IdxW-1:0]) + k;
    w = p[PtrW-1];
    if (s >= FlSize) begin
      s = s - FlSize;
      w = ~w;
    end
    return {w, IdxW'(s)};
  endfunction

  function automatic logic [PtrW-1:0] ptr_diff(logic [PtrW-1:0] t, logic [PtrW-1:0] h);
    int unsigned d;
    d = 32'(t[IdxW-1:0]) - 32'(h[IdxW-1:0]);
    if (t[PtrW-1] != h[PtrW-1]) d = d + FlSize;
    return PtrW'(d);
  endfunction

  logic [TagW-1:0] entry_q [FlSize];
  logic [TagW-1:0] entry_d [FlSize];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PtrW-1:0] nhead, slot_rd, avail;
  logic            err_q, err_d;
  logic            underflow, overflow, ckpt_we;
  logic [PtrW-1:0] wptr;
  int unsigned     n_disp, n_ret, room;

  freelist_ckpt_bank #(
    .NumCkpt (NUM_CKPT),
    .PtrW    (PtrW)
  ) u_bank (
    .clk_i   (clock),
    .rst_i   (reset),
    .we_i    (ckpt_we),
    .wid_i   (ckpt_id),
    .wdata_i (nhead),
    .rid_i   (restore_id),
    .rdata_o (slot_rd)
  );

  always_comb begin
    avail = ptr_diff(tail_q, head_q);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      free_valid[i] = 32'(avail) > i;
      free_tag[i]   = entry_q[ptr_add(head_q, i)];
    end
  end

  assign avail_cnt = avail;
  assign err       = err_q;

  always_comb begin
    n_disp    = 0;
    underflow = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (disp_en[i]) begin
        if (free_valid[i]) n_disp = n_disp + 1;
        else               underflow = 1'b1;
      end
    end
    nhead = ptr_add(head_q, n_disp);

    // Room is judged against registered occupancy; excess retires are dropped.
    room     = FlSize - 32'(avail);
    n_ret    = 0;
    overflow = 1'b0;
    wptr     = tail_q;
    entry_d  = entry_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (retire_en[i]) begin
        if (n_ret < room) begin
          wptr                      = ptr_add(tail_q, n_ret);
          entry_d[wptr[IdxW-1:0]]   = retire_tag[i];
          n_ret                     = n_ret + 1;
        end else begin
          overflow = 1'b1;
        end
      end
    end
    tail_d = ptr_add(tail_q, n_ret);

    ckpt_we = 1'b0;
    if (flush_en) begin
      head_d = {~tail_d[PtrW-1], tail_d[IdxW-1:0]};
    end else if (restore_en) begin
      head_d = slot_rd;
    end else begin
      head_d  = nhead;
      ckpt_we = ckpt_save;
    end

    err_d = err_q | overflow | (underflow & ~flush_en & ~restore_en);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < FlSize; i++) entry_q[i] <= TagW'(ARF_SIZE + i);
      head_q <= '0;
      tail_q <= {1'b1, {IdxW{1'b0}}};
      err_q  <= 1'b0;
    end else begin
      entry_q <= entry_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_freelist_ckpt.sv
// Randomised self-checking bench for freelist_ckpt against an absolute-index history model.
module tb_freelist_ckpt;
  import freelist_ckpt_pkg::*;

  localparam int W   = DEF_WIDTH;
  localparam int FL  = FL_SIZE;
  localparam int ARF = DEF_ARF_SIZE;
  localparam int NC  = DEF_NUM_CKPT;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [W-1:0]            disp_en, retire_en, free_valid;
  logic [W-1:0][TAG_W-1:0] free_tag, retire_tag;
  logic [PTR_W-1:0]        avail_cnt;
  logic                    ckpt_save, restore_en, flush_en, err;
  ckpt_id_t                ckpt_id, restore_id;

  always #5 clock = ~clock;

  freelist_ckpt dut (
    .clock      (clock),
    .reset      (reset),
    .disp_en    (disp_en),
    .free_tag   (free_tag),
    .free_valid (free_valid),
    .avail_cnt  (avail_cnt),
    .retire_en  (retire_en),
    .retire_tag (retire_tag),
    .ckpt_save  (ckpt_save),
    .ckpt_id    (ckpt_id),
    .restore_en (restore_en),
    .restore_id (restore_id),
    .flush_en   (flush_en),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;

  // Model: every tag ever placed in the list, indexed by absolute (never-wrapping) position.
  int hist[$];
  int head_a, tail_a;
  int ck[NC];
  bit m_err;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < FL; i++) hist.push_back(ARF + i);
    head_a = 0;
    tail_a = FL;
    for (int i = 0; i < NC; i++) ck[i] = 0;
    m_err = 1'b0;
  endtask

  task automatic model_step();
    int avail, room, nret, n;
    if (reset) return;
    avail = tail_a - head_a;
    room  = FL - avail;
    nret  = 0;
    for (int i = 0; i < W; i++) begin
      if (retire_en[i]) begin
        if (nret < room) begin
          hist.push_back(int'(retire_tag[i]));
          nret++;
        end else begin
          m_err = 1'b1;
        end
      end
    end
    tail_a += nret;
    if (flush_en) begin
      head_a = tail_a - FL;
    end else if (restore_en) begin
      head_a = ck[restore_id];
    end else begin
      n = 0;
      for (int i = 0; i < W; i++) begin
        if (disp_en[i]) begin
          if (i < avail) n++;
          else m_err = 1'b1;
        end
      end
      head_a += n;
      if (ckpt_save) ck[ckpt_id] = head_a;
    end
  endtask

  always @(negedge clock) begin
    int avail;
    if (cmp_en && !reset) begin
      avail = tail_a - head_a;
      chk("avail_cnt", int'(avail_cnt), avail);
      chk("err", int'(err), int'(m_err));
      for (int i = 0; i < W; i++) begin
        chk("free_valid", int'(free_valid[i]), int'(avail > i));
        if (avail > i) chk("free_tag", int'(free_tag[i]), hist[head_a + i]);
      end
    end
  end

  task automatic idle();
    disp_en    = '0;
    retire_en  = '0;
    retire_tag = '0;
    ckpt_save  = 1'b0;
    ckpt_id    = '0;
    restore_en = 1'b0;
    restore_id = '0;
    flush_en   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    model_reset();
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic rand_cycle(input bit allow_err);
    int avail, room, nd, nr, id, ntail;
    idle();
    avail = tail_a - head_a;
    room  = FL - avail;
    nd = int'($urandom_range(0, W));
    if (!allow_err && nd > avail) nd = avail;
    disp_en = W'((1 << nd) - 1);
    nr = int'($urandom_range(0, W));
    if (!allow_err && nr > room) nr = room;
    while ($countones(retire_en) < nr) retire_en[$urandom_range(0, W - 1)] = 1'b1;
    for (int i = 0; i < W; i++) retire_tag[i] = TAG_W'($urandom_range(0, DEF_PRF_SIZE - 1));
    if ($urandom_range(0, 5) == 0) begin
      ckpt_save = 1'b1;
      ckpt_id   = ckpt_id_t'($urandom_range(0, NC - 1));
    end
    if ($urandom_range(0, 9) == 0) begin
      id    = int'($urandom_range(0, NC - 1));
      ntail = tail_a + (nr < room ? nr : room);
      if (ck[id] <= head_a && ntail - ck[id] <= FL) begin
        restore_en = 1'b1;
        restore_id = ckpt_id_t'(id);
      end
    end
    if ($urandom_range(0, 49) == 0) flush_en = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    do_reset();
    cmp_en = 1'b1;

    chk("rst_avail", int'(avail_cnt), 32);
    chk("rst_tag0", int'(free_tag[0]), 32);
    chk("rst_tag1", int'(free_tag[1]), 33);
    chk("rst_valid", int'(free_valid), 3);
    chk("rst_err", int'(err), 0);

    disp_en = 2'b11;
    repeat (16) tick();
    idle();
    chk("empty_avail", int'(avail_cnt), 0);
    chk("empty_valid", int'(free_valid), 0);
    disp_en = 2'b01;
    tick();
    idle();
    chk("underflow_err", int'(err), 1);
    chk("underflow_avail", int'(avail_cnt), 0);

    do_reset();
    disp_en = 2'b11;
    repeat (2) tick();
    ckpt_save = 1'b1;
    ckpt_id   = 1;
    tick();
    ckpt_save = 1'b0;
    tick();
    idle();
    chk("pre_restore_avail", int'(avail_cnt), 24);
    restore_en = 1'b1;
    restore_id = 1;
    disp_en    = 2'b11;
    tick();
    idle();
    chk("restore_tag0", int'(free_tag[0]), 38);
    chk("restore_avail", int'(avail_cnt), 26);
    restore_en    = 1'b1;
    restore_id    = 1;
    retire_en     = 2'b10;
    retire_tag[1] = 5;
    tick();
    idle();
    chk("restore_ret_avail", int'(avail_cnt), 27);
    chk("restore_ret_tag0", int'(free_tag[0]), 38);

    disp_en = 2'b11;
    repeat (12) tick();
    idle();
    chk("drain_avail", int'(avail_cnt), 3);
    chk("drain_tag0", int'(free_tag[0]), 62);
    disp_en = 2'b01;
    tick();
    idle();
    chk("wrap_tag_5", int'(free_tag[1]), 5);
    retire_en  = 2'b11;
    retire_tag = {TAG_W'(41), TAG_W'(40)};
    tick();
    retire_en  = 2'b01;
    retire_tag = {TAG_W'(0), TAG_W'(42)};
    tick();
    retire_tag = {TAG_W'(0), TAG_W'(43)};
    flush_en   = 1'b1;
    disp_en    = 2'b11;
    tick();
    idle();
    chk("flush_avail", int'(avail_cnt), 32);
    chk("flush_err", int'(err), 0);
    chk("flush_tag0", int'(free_tag[0]), 37);

    disp_en = 2'b11;
    tick();
    for (int c = 0; c < 40; c++) begin
      disp_en   = 2'b11;
      retire_en = 2'b11;
      for (int i = 0; i < W; i++) retire_tag[i] = TAG_W'($urandom_range(0, DEF_PRF_SIZE - 1));
      tick();
    end
    idle();
    chk("wrap_avail", int'(avail_cnt), 30);
    chk("wrap_err", int'(err), 0);

    for (int c = 0; c < 3000; c++) rand_cycle(1'b0);
    chk("legal_err", int'(err), 0);
    for (int c = 0; c < 300; c++) rand_cycle(1'b1);
    idle();

    do_reset();
    disp_en = 2'b11;
    repeat (2) tick();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_avail", int'(avail_cnt), 32);
    chk("async_tag0", int'(free_tag[0]), 32);
    chk("async_tag1", int'(free_tag[1]), 33);
    chk("async_valid", int'(free_valid), 3);
    chk("async_err", int'(err), 0);
    idle();
    @(negedge clock);
    #2 reset = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
